muldiv_unit: RTL and testbench

Multi-cycle RV64M multiply/divide unit in the execute stage, directly downstream of the execute pipeline register. It consumes the operands and M-extension opcode latched in the execute-stage data, then computes iteratively. While it works, it raises a stall so the hazard unit holds the execute register (EWrite = hold). It returns the 64-bit result with a one-cycle done pulse.

---
 rtl/muldiv_pkg.sv | 27 ++
 rtl/muldiv_unit_div_iter.sv | 78 +++++++
 rtl/muldiv_unit.sv | 155 +++++++++++++++
 tb/tb_muldiv_unit.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared types and opcode predicates for the RV64M multiply/divide unit.
package muldiv_pkg;

  typedef enum logic [3:0] {
    OP_MUL, OP_MULW, OP_DIV, OP_DIVU, OP_REM, OP_REMU,
    OP_DIVW, OP_DIVUW, OP_REMW, OP_REMUW
  } muldiv_op_t;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} muldiv_state_t;

  function automatic logic is_div(input muldiv_op_t op);
    return !(op inside {OP_MUL, OP_MULW});
  endfunction

  function automatic logic is_word(input muldiv_op_t op);
    return op inside {OP_MULW, OP_DIVW, OP_DIVUW, OP_REMW, OP_REMUW};
  endfunction

  function automatic logic is_rem(input muldiv_op_t op);
    return op inside {OP_REM, OP_REMU, OP_REMW, OP_REMUW};
  endfunction

  function automatic logic is_signed_div(input muldiv_op_t op);
    return op inside {OP_DIV, OP_REM, OP_DIVW, OP_REMW};
  endfunction

endpackage

// File: rtl/muldiv_unit_div_iter.sv
// Restoring divider on operand magnitudes: one quotient bit per cycle
// (first bit in the start cycle), then a sign fix-up cycle flagged by done.
module div_iter #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         kill,
  input  logic         start,
  input  logic         word,
  input  logic         neg_q,
  input  logic         neg_r,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder
);
  localparam int CW = $clog2(W) + 1;

  logic [W-1:0]  rem_q, quo_q, dvs_q;
  logic [CW-1:0] cnt_q, iters;
  logic          busy_q, nq_q, nr_q, word_q;
  logic [W-1:0]  rem_in, quo_in, dvs_in, rem_n, quo_n;
  logic [W:0]    sh;
  logic          ge;

  // W ops park the 32-bit dividend in the upper half so MSB-first shifting works
  always_comb begin
    rem_in = start ? '0 : rem_q;
    quo_in = start ? (word ? {dividend[W/2-1:0], {(W/2){1'b0}}} : dividend) : quo_q;
    dvs_in = start ? divisor : dvs_q;
    sh     = {rem_in, quo_in[W-1]};
    ge     = (sh >= {1'b0, dvs_in});
    rem_n  = ge ? W'(sh - {1'b0, dvs_in}) : sh[W-1:0];
    quo_n  = {quo_in[W-2:0], ge};
  end

  assign iters     = word_q ? CW'(W/2) : CW'(W);
  assign busy      = busy_q;
  assign done      = busy_q && (cnt_q == iters);
  assign quotient  = nq_q ? -quo_q : quo_q;
  assign remainder = nr_q ? -rem_q : rem_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      nq_q   <= 1'b0;
      nr_q   <= 1'b0;
      word_q <= 1'b0;
    end else if (kill) begin
      busy_q <= 1'b0;
    end else if (start) begin
      rem_q  <= rem_n;
      quo_q  <= quo_n;
      dvs_q  <= divisor;
      cnt_q  <= CW'(1);
      busy_q <= 1'b1;
      nq_q   <= neg_q;
      nr_q   <= neg_r;
      word_q <= word;
    end else if (busy_q) begin
      if (cnt_q == iters) begin
        busy_q <= 1'b0;
      end else begin
        rem_q <= rem_n;
        quo_q <= quo_n;
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Execute-stage multi-cycle M-extension unit: FSM, divide special cases,
// multiply path and result muxing; the iterative divide lives in div_iter.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN       = 64,
  parameter int MUL_CYCLES = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            valid,
  input  muldiv_op_t      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] result
);
  localparam int HW = XLEN / 2;
  localparam logic [HW-1:0]   HMIN = {1'b1, {(HW-1){1'b0}}};
  localparam logic [XLEN-1:0] XMIN = {1'b1, {(XLEN-1){1'b0}}};

  function automatic logic [XLEN-1:0] sext_w(input logic [XLEN-1:0] x);
    return {{HW{x[HW-1]}}, x[HW-1:0]};
  endfunction

  function automatic logic [XLEN-1:0] mul_res(input muldiv_op_t o,
                                              input logic [XLEN-1:0] x, y);
    logic [XLEN-1:0] p;
    p = x * y;
    return (o == OP_MULW) ? sext_w(p) : p;
  endfunction

  muldiv_state_t   state_q, state_d;
  muldiv_op_t      op_q;
  logic [7:0]      cnt_q, cnt_d;
  logic [XLEN-1:0] a_q, b_q, result_q, result_d;
  logic            res_ld, start;
  logic            word, sgn, b_zero, ovf, special;
  logic [XLEN-1:0] a_ext, b_ext, mag_a, mag_b, spec_val, div_res;
  logic            div_busy, div_done;
  logic [XLEN-1:0] div_quo, div_rem;

  always_comb begin
    word   = is_word(op);
    sgn    = is_signed_div(op);
    a_ext  = word ? (sgn ? sext_w(a) : {{HW{1'b0}}, a[HW-1:0]}) : a;
    b_ext  = word ? (sgn ? sext_w(b) : {{HW{1'b0}}, b[HW-1:0]}) : b;
    b_zero = (b_ext == '0);
    ovf    = sgn && (word ? (a[HW-1:0] == HMIN && b[HW-1:0] == '1)
                          : (a == XMIN && b == '1));
    special  = is_div(op) && (b_zero || ovf);
    spec_val = is_rem(op) ? (b_zero ? a_ext : '0) : (b_zero ? '1 : a_ext);
    if (word) spec_val = sext_w(spec_val);
    mag_a = (sgn && a_ext[XLEN-1]) ? -a_ext : a_ext;
    mag_b = (sgn && b_ext[XLEN-1]) ? -b_ext : b_ext;
    start = !reset && !flush && valid && (state_q == S_IDLE || state_q == S_DONE);
    div_res = is_rem(op_q) ? div_rem : div_quo;
    if (is_word(op_q)) div_res = sext_w(div_res);
  end

  div_iter #(.W(XLEN)) u_div (
    .clk      (clk),
    .reset    (reset),
    .kill     (flush),
    .start    (start && is_div(op) && !special),
    .word     (word),
    .neg_q    (sgn && (a_ext[XLEN-1] ^ b_ext[XLEN-1])),
    .neg_r    (sgn && a_ext[XLEN-1]),
    .dividend (mag_a),
    .divisor  (mag_b),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (div_quo),
    .remainder(div_rem)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    res_ld   = 1'b0;
    result_d = result_q;
    case (state_q)
      S_IDLE, S_DONE: state_d = S_IDLE;
      S_MUL: begin
        if (cnt_q == 8'(MUL_CYCLES - 2)) begin
          state_d  = S_DONE;
          res_ld   = 1'b1;
          result_d = mul_res(op_q, a_q, b_q);
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_DIV: begin
        if (div_done) begin
          state_d  = S_DONE;
          res_ld   = 1'b1;
          result_d = div_res;
        end else if (!div_busy) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // a start out of DONE overrides the return to IDLE (back-to-back issue)
    if (start) begin
      cnt_d = '0;
      if (!is_div(op)) begin
        if (MUL_CYCLES == 1) begin
          state_d  = S_DONE;
          res_ld   = 1'b1;
          result_d = mul_res(op, a, b);
        end else begin
          state_d = S_MUL;
        end
      end else if (special) begin
        state_d  = S_DONE;
        res_ld   = 1'b1;
        result_d = spec_val;
      end else begin
        state_d = S_DIV;
      end
    end
    if (flush) begin
      state_d = S_IDLE;
      res_ld  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      op_q     <= OP_MUL;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (start) begin
        op_q <= op;
        a_q  <= a;
        b_q  <= b;
      end
      if (res_ld) result_q <= result_d;
    end
  end

  assign stall  = !reset && !flush && (state_q == S_MUL || state_q == S_DIV || start);
  assign done   = (state_q == S_DONE);
  assign result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed vector table plus hand sequences for flush, reset and back-to-back issue.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        valid = 1'b0;
  muldiv_op_t  op = OP_MUL;
  logic [63:0] a = '0, b = '0;
  logic        flush = 1'b0;
  logic        stall, done;
  logic [63:0] result;

  int checks = 0;
  int fails  = 0;

  typedef struct {
    string       nm;
    muldiv_op_t  op;
    logic [63:0] a, b;
    int          lat;
    logic [63:0] res;
  } vec_t;

  vec_t vecs[$];

  muldiv_unit #(.XLEN(64), .MUL_CYCLES(3)) dut (
    .clk(clk), .reset(reset), .valid(valid), .op(op), .a(a), .b(b),
    .flush(flush), .stall(stall), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // called at the negedge of the start cycle, after valid has been raised
  task automatic wait_done(input string nm, input int exp_lat, input logic [63:0] exp_res);
    int lat;
    @(negedge clk);
    valid = 1'b0;
    lat = 1;
    while (!done && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    check({nm, " latency"}, 64'(lat), 64'(exp_lat));
    check({nm, " result"}, result, exp_res);
  endtask

  task automatic issue(input string nm, input muldiv_op_t o, input logic [63:0] x, input logic [63:0] y);
    valid = 1'b1; op = o; a = x; b = y;
    #1;
    check({nm, " start stall"}, 64'(stall), 64'd1);
  endtask

  task automatic run_op(input vec_t v);
    @(negedge clk);
    issue(v.nm, v.op, v.a, v.b);
    wait_done(v.nm, v.lat, v.res);
  endtask

  initial begin
    int ndone;
    vecs.push_back('{"mul 7*-3",      OP_MUL,   64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 3,  64'hFFFF_FFFF_FFFF_FFEB});
    vecs.push_back('{"div -20/3",     OP_DIV,   64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 65, 64'hFFFF_FFFF_FFFF_FFFA});
    vecs.push_back('{"rem -20%3",     OP_REM,   64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 65, 64'hFFFF_FFFF_FFFF_FFFE});
    vecs.push_back('{"divu 5/0",      OP_DIVU,  64'd5, 64'd0, 1, 64'hFFFF_FFFF_FFFF_FFFF});
    vecs.push_back('{"remu 5%0",      OP_REMU,  64'd5, 64'd0, 1, 64'd5});
    vecs.push_back('{"div ovf",       OP_DIV,   64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1, 64'h8000_0000_0000_0000});
    vecs.push_back('{"rem ovf",       OP_REM,   64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1, 64'd0});
    vecs.push_back('{"divw ovf",      OP_DIVW,  64'h8000_0000, 64'hFFFF_FFFF, 1, 64'hFFFF_FFFF_8000_0000});
    vecs.push_back('{"divuw",         OP_DIVUW, 64'h1_0000_0064, 64'd7, 33, 64'd14});
    vecs.push_back('{"mulw sext",     OP_MULW,  64'h7FFF_FFFF, 64'd2, 3, 64'hFFFF_FFFF_FFFF_FFFE});
    vecs.push_back('{"mul -1*-1",     OP_MUL,   64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 3, 64'd1});
    vecs.push_back('{"divu 100/7",    OP_DIVU,  64'd100, 64'd7, 65, 64'd14});
    vecs.push_back('{"remu 100%7",    OP_REMU,  64'd100, 64'd7, 65, 64'd2});
    vecs.push_back('{"remw -7%2",     OP_REMW,  64'h1234_5678_FFFF_FFF9, 64'd2, 33, 64'hFFFF_FFFF_FFFF_FFFF});
    vecs.push_back('{"divw -7/2",     OP_DIVW,  64'h1234_5678_FFFF_FFF9, 64'd2, 33, 64'hFFFF_FFFF_FFFF_FFFD});
    vecs.push_back('{"remuw by0",     OP_REMUW, 64'd5, 64'h1_0000_0000, 1, 64'd5});
    vecs.push_back('{"div 7/-2",      OP_DIV,   64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 65, 64'hFFFF_FFFF_FFFF_FFFD});
    vecs.push_back('{"rem 7%-2",      OP_REM,   64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 65, 64'd1});

    repeat (3) @(negedge clk);
    #1;
    check("reset stall", 64'(stall), 64'd0);
    reset = 1'b0;
    #1;
    check("reset done", 64'(done), 64'd0);
    check("reset result", result, 64'd0);
    check("idle stall", 64'(stall), 64'd0);

    // MUL stall profile: start..start+2 high, low in the done cycle
    @(negedge clk);
    issue("mul prof", OP_MUL, 64'd3, 64'd5);
    @(negedge clk); valid = 1'b0; #1;
    check("mul prof s+1 stall", 64'(stall), 64'd1);
    @(negedge clk); #1;
    check("mul prof s+2 stall", 64'(stall), 64'd1);
    check("mul prof s+2 done", 64'(done), 64'd0);
    @(negedge clk); #1;
    check("mul prof s+3 done", 64'(done), 64'd1);
    check("mul prof s+3 stall", 64'(stall), 64'd0);
    check("mul prof result", result, 64'd15);
    @(negedge clk); #1;
    check("mul prof pulse", 64'(done), 64'd0);

    foreach (vecs[i]) run_op(vecs[i]);

    repeat (4) @(negedge clk);
    check("result hold", result, vecs[vecs.size()-1].res);

    // back-to-back: new start in the DONE cycle
    @(negedge clk);
    issue("b2b first", OP_MUL, 64'd2, 64'd3);
    wait_done("b2b first", 3, 64'd6);
    issue("b2b second", OP_MUL, 64'd4, 64'd5);
    check("b2b done cycle", 64'(done), 64'd1);
    wait_done("b2b second", 3, 64'd20);

    // flush mid-divide, then a MUL right behind it
    @(negedge clk);
    issue("flush div", OP_DIV, 64'd1000, 64'd3);
    ndone = 0;
    @(negedge clk); valid = 1'b0;
    for (int i = 1; i < 10; i++) begin
      #1;
      if (done) ndone++;
      if (i == 5) check("flush div busy stall", 64'(stall), 64'd1);
      @(negedge clk);
    end
    flush = 1'b1;
    #1;
    check("flush cycle stall", 64'(stall), 64'd0);
    @(negedge clk);
    flush = 1'b0;
    #1;
    check("post flush stall", 64'(stall), 64'd0);
    check("post flush done", 64'(done), 64'd0);
    issue("mul after flush", OP_MUL, 64'd6, 64'd7);
    wait_done("mul after flush", 3, 64'd42);
    for (int i = 0; i < 70; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("no stray done", 64'(ndone), 64'd0);
    check("flush result kept", result, 64'd42);

    // flush beats valid
    @(negedge clk);
    valid = 1'b1; flush = 1'b1; op = OP_MUL; a = 64'd9; b = 64'd9;
    #1;
    check("flush+valid stall", 64'(stall), 64'd0);
    @(negedge clk);
    valid = 1'b0; flush = 1'b0;
    ndone = 0;
    for (int i = 0; i < 5; i++) begin
      #1;
      if (done || stall) ndone++;
      @(negedge clk);
    end
    check("flush+valid ignored", 64'(ndone), 64'd0);

    // reset mid-divide
    issue("rst div", OP_DIVU, 64'd77, 64'd5);
    @(negedge clk); valid = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    #1;
    check("mid reset stall", 64'(stall), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("mid reset done", 64'(done), 64'd0);
    check("mid reset result", result, 64'd0);
    check("mid reset idle", 64'(stall), 64'd0);
    ndone = 0;
    for (int i = 0; i < 70; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("mid reset no done", 64'(ndone), 64'd0);
    run_op('{"after reset", OP_DIVU, 64'd77, 64'd5, 65, 64'd15});

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
